cnn_result_out: RTL and testbench
=================================

Name: cnn_result_out

Overview:
- Return path of the CNN accelerator.
- Accepts the final layer's class scores as a byte stream and buffers them in a small RAM.
- Tracks a running argmax and exposes scores, argmax and status to the host over the same Avalon-MM slave style as the load path: 8-bit data, 19-bit address, chipselect/read/write.
- Host polls status, then reads the result bytes.

Parameters:
- N_CLASSES, 53, number of class scores per inference.
- ADDR_SIZE, 19, host address width.
- IDX_BITS, 6, width of the class index; must satisfy 2^IDX_BITS >= N_CLASSES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- res_valid  in  1  score beat valid from the last layer.
- res_data  in  8  signed score, two's complement.
- res_last  in  1  marks the final beat of an inference.
- res_ready  out  1  block can accept a beat.
- chipselect  in  1  Avalon chip select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  ADDR_SIZE  Avalon word address.
- writedata  in  8  Avalon write data.
- readdata  out  8  registered read data.
- busy  out  1  collection in progress.

Behaviour:
- Reset values (reset==0 at clk edge):
  - state=IDLE, res_ready=0, busy=0, readdata=0.
  - count=0, max_val=-128, max_idx=0, done=0, overflow=0.
  - RAM contents are not cleared.
- States:
  - IDLE: res_ready=1, busy=0. The first accepted beat (res_valid&res_ready) moves to COLLECT.
  - COLLECT: res_ready=1, busy=1. A beat with res_last moves to DONE. count==N_CLASSES without res_last also moves to DONE.
  - DONE: res_ready=0, done=1. The host arm command moves to IDLE and clears count, done, overflow, max_val and max_idx.
- Beat accept:
  - Write res_data to RAM[count], count<=count+1.
  - If $signed(res_data) > max_val, update max_val and max_idx<=count. Strict greater-than, so the first index wins ties.
  - The beat accepted in IDLE is processed identically.
- Short frame: res_last with count+1 < N_CLASSES goes to DONE; the unwritten entries hold stale data.
- Over-long frame: a beat arriving in DONE is not accepted, since res_ready=0. overflow is set when res_valid=1 while in DONE before re-arm; the beat is dropped.
- Host read map (valid when chipselect&read):
  - addr 0..N_CLASSES-1: RAM score.
  - 0x40: status {5'b0, overflow, busy, done}.
  - 0x41: {2'b0, max_idx}.
  - 0x42: count.
  - 0x43: max_val.
  - Any other address returns 0x00.
- Read latency: readdata is valid exactly 1 cycle after the read strobe and holds until the next read.
- Host write map (chipselect&write):
  - addr 0x7F with writedata[0]=1: arm. Takes effect in any state, including COLLECT, where it aborts the partial frame.
  - Other writes are ignored.
- Simultaneous arm and accepted beat: arm wins and the beat is discarded. res_ready is forced to 0 in the arm cycle.
- A host read of a score address while a beat is being written to that address returns the old RAM value (read-before-write).
- Mid-operation reset returns to IDLE on the next edge; any in-progress frame is lost.

Optional Feature:
- Macro RESULT_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, reset 0).
  - irq is set on the cycle DONE is entered and held until the host arms or writes addr 0x7E with writedata[0]=1, which clears irq only.
  - Status bit 3 reflects irq.
- When undefined: no irq port, addr 0x7E is ignored, status bit 3 reads 0.

Decomposition:
- Package cnn_pkg:
  - score_t (logic signed [7:0]).
  - Address constants RES_STATUS_ADDR=0x40, RES_ARGMAX_ADDR=0x41, RES_COUNT_ADDR=0x42, RES_MAXVAL_ADDR=0x43, RES_IRQCLR_ADDR=0x7E, RES_ARM_ADDR=0x7F.
  - FSM enum res_state_t {IDLE, COLLECT, DONE}.
- Sub-module result_ram: dual-port, N_CLASSES x 8. One synchronous write port and one registered read port, read-before-write on address collision.

Test Plan:
- 53 beats, scores i-26 for index i, last on beat 52 -> status=0x01, argmax=52, count=53, max_val=26; reading addr 10 returns 0xF0 one cycle after the strobe.
- Beats 5,9,9,-3 with last on beat 3 -> argmax=1 (tie goes to the first), count=4, max_val=9.
- After DONE, hold res_valid=1 with no arm -> res_ready=0, status=0x05 (overflow set); RAM unchanged.
- Arm write (0x7F, 0x01) in the same cycle as a valid beat during COLLECT -> state IDLE, count=0, beat discarded, status=0x00.
- All-negative frame of -128 x53 -> argmax=0, max_val=0x80; read of addr 0x50 returns 0x00.
- With RESULT_IRQ_EN: irq rises on the DONE-entry edge, a write (0x7E, 0x01) clears irq and status stays done=1; apply reset=0 for one cycle mid-COLLECT -> all outputs at their reset values.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and host address map for the CNN result return path.
// Contents: score_t (signed 8-bit class score), host register addresses,
// and the result collector FSM state type.
package cnn_pkg;

    typedef logic signed [7:0] score_t;

    localparam int unsigned RES_STATUS_ADDR = 32'h40;
    localparam int unsigned RES_ARGMAX_ADDR = 32'h41;
    localparam int unsigned RES_COUNT_ADDR  = 32'h42;
    localparam int unsigned RES_MAXVAL_ADDR = 32'h43;
    localparam int unsigned RES_IRQCLR_ADDR = 32'h7E;
    localparam int unsigned RES_ARM_ADDR    = 32'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } res_state_t;

endpackage

// File: rtl/cnn_result_out_if.sv
// Bus bundle for cnn_result_out.
// Carries the score stream from the last layer (res_valid/res_data/
// res_last/res_ready) and the Avalon-MM host slave signals
// (chipselect/read/write/address/writedata/readdata).
// Modports: master = stream source + host, slave = cnn_result_out.
interface cnn_result_out_if #(
    parameter int ADDR_SIZE = 19
);
    logic                 res_valid;
    logic [7:0]           res_data;
    logic                 res_last;
    logic                 res_ready;
    logic                 chipselect;
    logic                 read;
    logic                 write;
    logic [ADDR_SIZE-1:0] address;
    logic [7:0]           writedata;
    logic [7:0]           readdata;

    modport master (
        output res_valid, res_data, res_last,
        output chipselect, read, write, address, writedata,
        input  res_ready, readdata
    );

    modport slave (
        input  res_valid, res_data, res_last,
        input  chipselect, read, write, address, writedata,
        output res_ready, readdata
    );
endinterface

// File: rtl/cnn_result_out_ram.sv
// result_ram: score buffer, DEPTH x 8.
// One synchronous write port, one registered read port. On an address
// collision the read returns the value held before the write.
// Ports: clk; we/waddr/wdata write port; re/raddr read request;
// rdata registered read data (updates only when re is high).
module result_ram #(
    parameter int DEPTH = 53,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/cnn_result_out.sv
// cnn_result_out: return path of the CNN accelerator.
// Collects one inference's class scores from the byte stream into
// result_ram, tracks a running argmax (first index wins ties) and exposes
// scores, argmax, count, max value and status to the host over an
// Avalon-MM style slave with one-cycle registered read latency.
// Ports:
//   clk   - system clock
//   reset - synchronous active-low reset
//   host  - cnn_result_out_if.slave (score stream + Avalon host bus)
//   busy  - collection in progress
//   irq   - done interrupt (only when RESULT_IRQ_EN is defined)
// Host map: 0..N_CLASSES-1 scores, 0x40 status {irq,overflow,busy,done},
// 0x41 argmax, 0x42 count, 0x43 max value; write 0x7F[0]=1 arms,
// write 0x7E[0]=1 clears irq.
// Optional build macro: RESULT_IRQ_EN.
module cnn_result_out
    import cnn_pkg::*;
#(
    parameter int N_CLASSES = 53,
    parameter int ADDR_SIZE = 19,
    parameter int IDX_BITS  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    cnn_result_out_if.slave        host,
    output logic                   busy
`ifdef RESULT_IRQ_EN
    ,
    output logic                   irq
`endif
);
    localparam int CNT_BITS = $clog2(N_CLASSES + 1);

    res_state_t          state;
    logic [CNT_BITS-1:0] count;
    score_t              max_val;
    logic [IDX_BITS-1:0] max_idx;
    logic                overflow;
    logic                done;
    logic                irq_bit;

    logic   host_wr;
    logic   host_rd;
    logic   arm;
    logic   accept;
    logic   last_beat;
    score_t score_in;

    logic       is_ram_addr;
    logic       rd_sel_ram;
    logic [7:0] reg_rdata;
    logic [7:0] reg_mux;
    logic [7:0] ram_rdata;

    logic unused_wdata;
    assign unused_wdata = ^host.writedata[7:1];

    assign host_wr  = host.chipselect & host.write;
    assign host_rd  = host.chipselect & host.read;
    assign arm      = host_wr && (host.address == ADDR_SIZE'(RES_ARM_ADDR))
                      && host.writedata[0];
    assign score_in = score_t'(host.res_data);

    // Arm takes priority over an incoming beat, so ready drops in the arm cycle.
    assign host.res_ready = reset && (state != DONE) && !arm;
    assign accept         = host.res_valid && host.res_ready;
    assign last_beat      = accept &&
                            (host.res_last || (count == CNT_BITS'(N_CLASSES - 1)));

    assign done = (state == DONE);
    assign busy = (state == COLLECT);

`ifdef RESULT_IRQ_EN
    logic irq_clr;
    assign irq_clr = host_wr && (host.address == ADDR_SIZE'(RES_IRQCLR_ADDR))
                     && host.writedata[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (arm) begin
            irq <= 1'b0;
        end else if (last_beat) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
    assign irq_bit = irq;
`else
    assign irq_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            max_val  <= score_t'(8'h80);
            max_idx  <= '0;
            overflow <= 1'b0;
        end else if (arm) begin
            state    <= IDLE;
            count    <= '0;
            max_val  <= score_t'(8'h80);
            max_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                count <= count + 1'b1;
                if (score_in > max_val) begin
                    max_val <= score_in;
                    max_idx <= IDX_BITS'(count);
                end
            end
            case (state)
                // A one-beat frame (res_last on the first beat) completes directly.
                IDLE:    if (accept) state <= last_beat ? DONE : COLLECT;
                COLLECT: if (last_beat) state <= DONE;
                DONE:    if (host.res_valid) overflow <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    result_ram #(
        .DEPTH (N_CLASSES),
        .AW    (IDX_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (IDX_BITS'(count)),
        .wdata (host.res_data),
        .re    (host_rd && is_ram_addr),
        .raddr (IDX_BITS'(host.address)),
        .rdata (ram_rdata)
    );

    assign is_ram_addr = (host.address < ADDR_SIZE'(N_CLASSES));

    always_comb begin
        reg_mux = '0;
        case (host.address)
            ADDR_SIZE'(RES_STATUS_ADDR): reg_mux = {4'b0, irq_bit, overflow, busy, done};
            ADDR_SIZE'(RES_ARGMAX_ADDR): reg_mux = 8'(max_idx);
            ADDR_SIZE'(RES_COUNT_ADDR):  reg_mux = 8'(count);
            ADDR_SIZE'(RES_MAXVAL_ADDR): reg_mux = max_val;
            default:                     reg_mux = '0;
        endcase
    end

    // Score reads come straight from the RAM's output register; the select
    // flag is captured with the strobe so readdata holds until the next read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_rdata  <= '0;
            rd_sel_ram <= 1'b0;
        end else if (host_rd) begin
            rd_sel_ram <= is_ram_addr;
            reg_rdata  <= is_ram_addr ? 8'h00 : reg_mux;
        end
    end

    assign host.readdata = rd_sel_ram ? ram_rdata : reg_rdata;

endmodule

// File: tb/tb_cnn_result_out.sv
module tb_cnn_result_out;
    import cnn_pkg::*;

`ifdef RESULT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  exp;
    } vec_t;

    logic clk;
    logic reset;
    logic busy;
`ifdef RESULT_IRQ_EN
    logic irq;
`endif

    int n_checks;
    int n_pass;
    bit exp_irq;
    vec_t tbl[$];

    cnn_result_out_if #(.ADDR_SIZE(19)) bus ();

    cnn_result_out #(
        .N_CLASSES (53),
        .ADDR_SIZE (19),
        .IDX_BITS  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (bus),
        .busy  (busy)
`ifdef RESULT_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] st(input logic [7:0] base);
        return base | ((IRQ_ON && exp_irq) ? 8'h08 : 8'h00);
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic last);
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        bus.res_last  = last;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
    endtask

    task automatic host_read(input logic [18:0] addr, output logic [7:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        data = bus.readdata;
    endtask

    task automatic host_write(input logic [18:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [18:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        host_read(addr, d);
        check(name, d, exp);
    endtask

    task automatic run_tbl(input string name);
        logic [7:0] d;
        logic [7:0] e;
        foreach (tbl[i]) begin
            host_read(tbl[i].addr, d);
            e = (tbl[i].addr == 19'h40) ? st(tbl[i].exp) : tbl[i].exp;
            check($sformatf("%s addr 0x%02h", name, tbl[i].addr), d, e);
        end
        tbl.delete();
    endtask

    task automatic add(input logic [18:0] addr, input logic [7:0] exp);
        vec_t v;
        v.addr = addr;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] d;
        n_checks = 0;
        n_pass   = 0;
        exp_irq  = 1'b0;
        reset = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = 8'h00; bus.res_last = 1'b0;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = '0; bus.writedata = 8'h00;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("reset res_ready", {7'b0, bus.res_ready}, 8'h00);
        check("reset busy", {7'b0, busy}, 8'h00);
        check("reset readdata", bus.readdata, 8'h00);
`ifdef RESULT_IRQ_EN
        check("reset irq", {7'b0, irq}, 8'h00);
`endif
        @(negedge clk); reset = 1'b1;
        #1 check("idle res_ready", {7'b0, bus.res_ready}, 8'h01);
        add(19'h40, 8'h00); add(19'h41, 8'h00); add(19'h42, 8'h00); add(19'h43, 8'h80);
        run_tbl("post-reset");

        // Frame 1: 53 beats, score i-26, last on beat 52
        for (int i = 0; i < 53; i++) begin
            if (i == 52) begin
`ifdef RESULT_IRQ_EN
                check("f1 irq before last", {7'b0, irq}, 8'h00);
`endif
                check("f1 busy", {7'b0, busy}, 8'h01);
            end
            send_beat(8'(i - 26), i == 52);
        end
        exp_irq = 1'b1;
`ifdef RESULT_IRQ_EN
        check("f1 irq on done entry", {7'b0, irq}, 8'h01);
`endif
        check("f1 res_ready in DONE", {7'b0, bus.res_ready}, 8'h00);
        add(19'h40, 8'h01); add(19'h41, 8'd52); add(19'h42, 8'd53); add(19'h43, 8'h1A);
        add(19'd0, 8'hE6);  add(19'd10, 8'hF0); add(19'd26, 8'h00); add(19'd52, 8'h1A);
        add(19'd53, 8'h00); add(19'h50, 8'h00); add(19'h7F, 8'h00); add(19'h44, 8'h00);
        run_tbl("f1");

        // Over-long frame: valid held in DONE without arm
        @(negedge clk);
        bus.res_valid = 1'b1; bus.res_data = 8'h55; bus.res_last = 1'b0;
        #1 check("ovf res_ready", {7'b0, bus.res_ready}, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        bus.res_valid = 1'b0;
        rd_check("ovf status", 19'h40, st(8'h05));
        rd_check("ovf ram unchanged", 19'd0, 8'hE6);
        rd_check("ovf count", 19'h42, 8'd53);

        // Re-arm
        host_write(19'h7F, 8'h01);
        exp_irq = 1'b0;
        add(19'h40, 8'h00); add(19'h42, 8'h00); add(19'h43, 8'h80); add(19'h41, 8'h00);
        run_tbl("arm");

        // Frame 2: short frame 5,9,9,-3 with tie
        send_beat(8'd5, 1'b0);
        send_beat(8'd9, 1'b0);
        send_beat(8'd9, 1'b0);
        send_beat(8'hFD, 1'b1);
        exp_irq = 1'b1;
`ifdef RESULT_IRQ_EN
        check("f2 irq", {7'b0, irq}, 8'h01);
`endif
        add(19'h40, 8'h01); add(19'h41, 8'h01); add(19'h42, 8'h04); add(19'h43, 8'h09);
        add(19'd1, 8'h09);  add(19'd3, 8'hFD);  add(19'd4, 8'hEA);
        run_tbl("f2");

        // Irq clear write: clears irq only (ignored in the default build)
        host_write(19'h7E, 8'h01);
        exp_irq = 1'b0;
`ifdef RESULT_IRQ_EN
        check("irqclr irq", {7'b0, irq}, 8'h00);
`endif
        rd_check("irqclr status", 19'h40, st(8'h01));

        // Arm during COLLECT concurrent with a valid beat
        host_write(19'h7F, 8'h01);
        send_beat(8'd7, 1'b0);
        send_beat(8'd3, 1'b0);
        check("f3 busy", {7'b0, busy}, 8'h01);
        @(negedge clk);
        bus.res_valid = 1'b1; bus.res_data = 8'h64; bus.res_last = 1'b0;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 19'h7F; bus.writedata = 8'h01;
        #1 check("arm+beat res_ready", {7'b0, bus.res_ready}, 8'h00);
        @(posedge clk); #1;
        bus.res_valid = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        check("arm+beat busy", {7'b0, busy}, 8'h00);
        add(19'h40, 8'h00); add(19'h42, 8'h00); add(19'h43, 8'h80); add(19'd2, 8'h09);
        run_tbl("arm+beat");

        // Read-before-write on score address 0
        @(negedge clk);
        bus.res_valid = 1'b1; bus.res_data = 8'h11; bus.res_last = 1'b0;
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 19'd0;
        @(posedge clk); #1;
        bus.res_valid = 1'b0; bus.chipselect = 1'b0; bus.read = 1'b0;
        check("rbw old value", bus.readdata, 8'h07);
        rd_check("rbw new value", 19'd0, 8'h11);
        check("rbw busy", {7'b0, busy}, 8'h01);

        // Reset mid-COLLECT
        send_beat(8'h22, 1'b0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("midrst res_ready", {7'b0, bus.res_ready}, 8'h00);
        check("midrst busy", {7'b0, busy}, 8'h00);
        check("midrst readdata", bus.readdata, 8'h00);
`ifdef RESULT_IRQ_EN
        check("midrst irq", {7'b0, irq}, 8'h00);
`endif
        @(negedge clk); reset = 1'b1;
        add(19'h40, 8'h00); add(19'h41, 8'h00); add(19'h42, 8'h00); add(19'h43, 8'h80);
        run_tbl("midrst");

        // All -128 frame, no res_last: completes on count reaching N_CLASSES
        for (int i = 0; i < 53; i++) begin
            send_beat(8'h80, 1'b0);
        end
        exp_irq = 1'b1;
        check("f4 res_ready", {7'b0, bus.res_ready}, 8'h00);
        add(19'h40, 8'h01); add(19'h41, 8'h00); add(19'h42, 8'd53); add(19'h43, 8'h80);
        add(19'd52, 8'h80); add(19'h50, 8'h00);
        run_tbl("f4");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
